exe_stage: RTL and testbench

- Execute stage sitting directly downstream of the ID/EXE pipeline register; consumes its decoded operands and control fields.
- Applies operand forwarding from the MEM and WB stages and performs the ALU operation. MUL runs as a 32-cycle shift-add sequence that stalls upstream.
- Registers the result plus pass-through control into an internal EXE/MEM register.

---
 rtl/exe_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_exe_stage.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding from MEM/WB, single-cycle ALU, a 32-step
// shift-add multiplier that stalls upstream, and the EXE/MEM output register.
module exe_stage #(
  parameter int XLEN       = 32,
  parameter int REGW       = 5,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] val1_in,
  input  logic [XLEN-1:0] val2_in,
  input  logic [XLEN-1:0] st_value_in,
  input  logic            val2_is_imm,
  input  logic [REGW-1:0] src1_in,
  input  logic [REGW-1:0] src2_in,
  input  logic [REGW-1:0] dest_in,
  input  logic [3:0]      exe_cmd_in,
  input  logic            wb_en_in,
  input  logic            mem_r_en_in,
  input  logic            mem_w_en_in,
  input  logic            mem_fwd_en,
  input  logic [REGW-1:0] mem_fwd_dest,
  input  logic [XLEN-1:0] mem_fwd_val,
  input  logic            wb_fwd_en,
  input  logic [REGW-1:0] wb_fwd_dest,
  input  logic [XLEN-1:0] wb_fwd_val,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] st_value,
  output logic [REGW-1:0] dest,
  output logic            wb_en,
  output logic            mem_r_en,
  output logic            mem_w_en
);

  localparam int             CNTW     = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MUL_CYCLES - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_AND = 4'd4;
  localparam logic [3:0] CMD_OR  = 4'd5;
  localparam logic [3:0] CMD_NOR = 4'd6;
  localparam logic [3:0] CMD_XOR = 4'd7;
  localparam logic [3:0] CMD_SLL = 4'd8;
  localparam logic [3:0] CMD_SRA = 4'd9;
  localparam logic [3:0] CMD_SRL = 4'd10;
  localparam logic [3:0] CMD_SLT = 4'd11;
  localparam logic [3:0] CMD_MUL = 4'd12;

  logic                   state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]        mcand_q, mcand_d;
  logic [XLEN-1:0]        mplier_q, mplier_d;
  logic [XLEN-1:0]        acc_q, acc_d;
  logic [XLEN-1:0]        cap_st_q, cap_st_d;
  logic [REGW-1:0]        cap_dest_q, cap_dest_d;
  logic                   cap_wb_q, cap_wb_d;
  logic                   cap_mr_q, cap_mr_d;
  logic                   cap_mw_q, cap_mw_d;

  logic [XLEN-1:0]        res_q, res_d;
  logic [XLEN-1:0]        st_q, st_d;
  logic [REGW-1:0]        dest_q, dest_d;
  logic                   wb_q, wb_d;
  logic                   mr_q, mr_d;
  logic                   mw_q, mw_d;

  logic [XLEN-1:0]        op1, op2, st_fwd, alu_res;
  logic signed [XLEN-1:0] op1_s, op2_s;
  logic [4:0]             shamt;
  logic                   mem_hit1, wb_hit1, mem_hit2, wb_hit2;
  logic                   is_mul, mul_issue, mul_last;
  logic [XLEN-1:0]        acc_step;

  // Register 0 is hard-wired, so it never matches a forwarding source.
  assign mem_hit1 = mem_fwd_en && (src1_in != '0) && (mem_fwd_dest == src1_in);
  assign wb_hit1  = wb_fwd_en  && (src1_in != '0) && (wb_fwd_dest  == src1_in);
  assign mem_hit2 = mem_fwd_en && (src2_in != '0) && (mem_fwd_dest == src2_in);
  assign wb_hit2  = wb_fwd_en  && (src2_in != '0) && (wb_fwd_dest  == src2_in);

  // Operand selection: MEM beats WB; immediates bypass forwarding but store data never does.
  always_comb begin
    op1 = val1_in;
    if (mem_hit1)     op1 = mem_fwd_val;
    else if (wb_hit1) op1 = wb_fwd_val;
    op2 = val2_in;
    if (!val2_is_imm) begin
      if (mem_hit2)     op2 = mem_fwd_val;
      else if (wb_hit2) op2 = wb_fwd_val;
    end
    st_fwd = st_value_in;
    if (mem_hit2)     st_fwd = mem_fwd_val;
    else if (wb_hit2) st_fwd = wb_fwd_val;
  end

  assign op1_s = op1;
  assign op2_s = op2;
  assign shamt = op2[4:0];

  // Single-cycle ALU; MUL and undefined codes yield 0 here.
  always_comb begin
    case (exe_cmd_in)
      CMD_ADD: alu_res = op1 + op2;
      CMD_SUB: alu_res = op1 - op2;
      CMD_AND: alu_res = op1 & op2;
      CMD_OR:  alu_res = op1 | op2;
      CMD_NOR: alu_res = ~(op1 | op2);
      CMD_XOR: alu_res = op1 ^ op2;
      CMD_SLL: alu_res = op1 << shamt;
      CMD_SRA: alu_res = op1_s >>> shamt;
      CMD_SRL: alu_res = op1 >> shamt;
      CMD_SLT: alu_res = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
      default: alu_res = '0;
    endcase
  end

  assign is_mul    = (exe_cmd_in == CMD_MUL);
  assign mul_issue = (state_q == ST_IDLE) && is_mul && !flush;
  assign mul_last  = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign stall     = mul_issue || ((state_q == ST_RUN) && (cnt_q != CNT_LAST) && !flush);

  // Multiplier sequencing: capture at issue, one shift-add step per RUN cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cap_st_d   = cap_st_q;
    cap_dest_d = cap_dest_q;
    cap_wb_d   = cap_wb_q;
    cap_mr_d   = cap_mr_q;
    cap_mw_d   = cap_mw_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      if (is_mul) begin
        state_d    = ST_RUN;
        cnt_d      = '0;
        mcand_d    = op1;
        mplier_d   = op2;
        acc_d      = '0;
        cap_st_d   = st_fwd;
        cap_dest_d = dest_in;
        cap_wb_d   = wb_en_in;
        cap_mr_d   = mem_r_en_in;
        cap_mw_d   = mem_w_en_in;
      end
    end else begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // EXE/MEM next value: bubble unless a single-cycle op or the final MUL step completes.
  always_comb begin
    res_d  = '0;
    st_d   = '0;
    dest_d = '0;
    wb_d   = 1'b0;
    mr_d   = 1'b0;
    mw_d   = 1'b0;
    if (!flush) begin
      if ((state_q == ST_IDLE) && !is_mul) begin
        res_d  = alu_res;
        st_d   = st_fwd;
        dest_d = dest_in;
        wb_d   = wb_en_in;
        mr_d   = mem_r_en_in;
        mw_d   = mem_w_en_in;
      end else if (mul_last) begin
        res_d  = acc_step;
        st_d   = cap_st_q;
        dest_d = cap_dest_q;
        wb_d   = cap_wb_q;
        mr_d   = cap_mr_q;
        mw_d   = cap_mw_q;
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cap_st_q   <= '0;
      cap_dest_q <= '0;
      cap_wb_q   <= 1'b0;
      cap_mr_q   <= 1'b0;
      cap_mw_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cap_st_q   <= cap_st_d;
      cap_dest_q <= cap_dest_d;
      cap_wb_q   <= cap_wb_d;
      cap_mr_q   <= cap_mr_d;
      cap_mw_q   <= cap_mw_d;
    end
  end

  // EXE/MEM output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q  <= '0;
      st_q   <= '0;
      dest_q <= '0;
      wb_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
    end else begin
      res_q  <= res_d;
      st_q   <= st_d;
      dest_q <= dest_d;
      wb_q   <= wb_d;
      mr_q   <= mr_d;
      mw_q   <= mw_d;
    end
  end

  assign alu_result = res_q;
  assign st_value   = st_q;
  assign dest       = dest_q;
  assign wb_en      = wb_q;
  assign mem_r_en   = mr_q;
  assign mem_w_en   = mw_q;

endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: directed scenarios plus randomized traffic checked
// against an arithmetic reference model.
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic [31:0] val1_in, val2_in, st_value_in;
  logic        val2_is_imm;
  logic [4:0]  src1_in, src2_in, dest_in;
  logic [3:0]  exe_cmd_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_dest, wb_fwd_dest;
  logic [31:0] mem_fwd_val, wb_fwd_val;
  logic        flush;
  logic        stall;
  logic [31:0] alu_result, st_value;
  logic [4:0]  dest;
  logic        wb_en, mem_r_en, mem_w_en;

  int checks = 0;
  int failures = 0;

  exe_stage #(.XLEN(32), .REGW(5), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .val1_in(val1_in), .val2_in(val2_in), .st_value_in(st_value_in),
    .val2_is_imm(val2_is_imm), .src1_in(src1_in), .src2_in(src2_in),
    .dest_in(dest_in), .exe_cmd_in(exe_cmd_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_dest(mem_fwd_dest), .mem_fwd_val(mem_fwd_val),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_val(wb_fwd_val),
    .flush(flush), .stall(stall),
    .alu_result(alu_result), .st_value(st_value), .dest(dest),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (cmd)
      4'd0:  return a + b;
      4'd2:  return a - b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a << b[4:0];
      4'd9:  return 32'($signed(a) >>> b[4:0]);
      4'd10: return a >> b[4:0];
      4'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: begin prod = 64'(a) * 64'(b); return prod[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] raw, input logic allow);
    if (!allow || src == 5'd0) return raw;
    if (mem_fwd_en && mem_fwd_dest == src) return mem_fwd_val;
    if (wb_fwd_en && wb_fwd_dest == src) return wb_fwd_val;
    return raw;
  endfunction

  task automatic clear_inputs();
    val1_in = '0; val2_in = '0; st_value_in = '0; val2_is_imm = 1'b0;
    src1_in = '0; src2_in = '0; dest_in = '0; exe_cmd_in = 4'd15;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    mem_fwd_en = 1'b0; mem_fwd_dest = '0; mem_fwd_val = '0;
    wb_fwd_en = 1'b0; wb_fwd_dest = '0; wb_fwd_val = '0;
    flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en} !== 72'd0) begin
      failures++; $display("FAIL reset_outputs: got %h/%h/%0d/%b%b%b expected all zero", alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en);
    end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
    exe_cmd_in = 4'd0; val1_in = 32'd5; val2_in = 32'd7; dest_in = 5'd3; wb_en_in = 1'b1;
    tick(); tick();
    checks++;
    if ({alu_result, dest, wb_en} !== 38'd0) begin
      failures++; $display("FAIL reset_held: got %h/%0d/%b expected zero while in reset", alu_result, dest, wb_en);
    end
    #2 rst = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_add();
    clear_inputs();
    exe_cmd_in = 4'd0; val1_in = 32'd5; val2_in = 32'd7; dest_in = 5'd3; wb_en_in = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL add_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if (alu_result !== 32'd12) begin failures++; $display("FAIL add_result: got %h expected %h", alu_result, 32'd12); end
    checks++;
    if ({dest, wb_en, mem_r_en, mem_w_en} !== {5'd3, 3'b100}) begin
      failures++; $display("FAIL add_ctrl: got dest=%0d ctl=%b%b%b expected dest=3 ctl=100", dest, wb_en, mem_r_en, mem_w_en);
    end
  endtask

  task automatic test_forwarding();
    // MEM and WB both match src1: MEM wins.
    clear_inputs();
    exe_cmd_in = 4'd2; val1_in = 32'h99; val2_in = 32'd1; src1_in = 5'd4;
    mem_fwd_en = 1'b1; mem_fwd_dest = 5'd4; mem_fwd_val = 32'h10;
    wb_fwd_en = 1'b1; wb_fwd_dest = 5'd4; wb_fwd_val = 32'h20;
    tick();
    checks++;
    if (alu_result !== 32'hF) begin failures++; $display("FAIL fwd_mem_priority: got %h expected %h", alu_result, 32'hF); end
    // Index 0 never forwarded.
    src1_in = 5'd0; mem_fwd_dest = 5'd0; wb_fwd_dest = 5'd0;
    tick();
    checks++;
    if (alu_result !== 32'h98) begin failures++; $display("FAIL fwd_reg0: got %h expected %h", alu_result, 32'h98); end
    // WB-only match.
    clear_inputs();
    exe_cmd_in = 4'd0; val1_in = 32'h5; val2_in = 32'd1; src1_in = 5'd6;
    mem_fwd_en = 1'b1; mem_fwd_dest = 5'd7; mem_fwd_val = 32'h10;
    wb_fwd_en = 1'b1; wb_fwd_dest = 5'd6; wb_fwd_val = 32'h20;
    tick();
    checks++;
    if (alu_result !== 32'h21) begin failures++; $display("FAIL fwd_wb_only: got %h expected %h", alu_result, 32'h21); end
    // Disabled MEM stage does not forward.
    clear_inputs();
    exe_cmd_in = 4'd0; val1_in = 32'h40; src1_in = 5'd4;
    mem_fwd_en = 1'b0; mem_fwd_dest = 5'd4; mem_fwd_val = 32'h10;
    tick();
    checks++;
    if (alu_result !== 32'h40) begin failures++; $display("FAIL fwd_disabled: got %h expected %h", alu_result, 32'h40); end
    // Immediate bypasses forwarding, store data is still forwarded.
    clear_inputs();
    exe_cmd_in = 4'd0; val1_in = 32'd1; val2_in = 32'd2; val2_is_imm = 1'b1; src2_in = 5'd5;
    st_value_in = 32'h55; mem_fwd_en = 1'b1; mem_fwd_dest = 5'd5; mem_fwd_val = 32'h100;
    tick();
    checks++;
    if (alu_result !== 32'd3) begin failures++; $display("FAIL fwd_imm_result: got %h expected %h", alu_result, 32'd3); end
    checks++;
    if (st_value !== 32'h100) begin failures++; $display("FAIL fwd_imm_store: got %h expected %h", st_value, 32'h100); end
  endtask

  task automatic test_shift_cmp();
    logic [3:0]  t_cmd [10] = '{4'd9, 4'd10, 4'd11, 4'd11, 4'd8, 4'd8, 4'd6, 4'd7, 4'd13, 4'd15};
    logic [31:0] t_a   [10] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1,
                                32'd0, 32'hF0F0_F0F0, 32'd9, 32'd5};
    logic [31:0] t_b   [10] = '{32'd4, 32'd4, 32'd1, 32'hFFFF_FFFF, 32'd31, 32'h21,
                                32'd0, 32'hFF00_FF00, 32'd3, 32'd5};
    logic [31:0] t_exp [10] = '{32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0, 32'h8000_0000, 32'd2,
                                32'hFFFF_FFFF, 32'h0FF0_0FF0, 32'd0, 32'd0};
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      exe_cmd_in = t_cmd[i]; val1_in = t_a[i]; val2_in = t_b[i];
      tick();
      checks++;
      if (alu_result !== t_exp[i]) begin
        failures++; $display("FAIL shift_cmp[%0d] cmd=%0d: got %h expected %h", i, t_cmd[i], alu_result, t_exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e_res, e_st;
    logic [4:0]  e_dest;
    logic [2:0]  e_ctl;
    for (int i = 0; i < 200; i++) begin
      exe_cmd_in = 4'($urandom_range(0, 15));
      if (exe_cmd_in == 4'd12) exe_cmd_in = 4'd0;
      val1_in = $urandom; val2_in = $urandom; st_value_in = $urandom;
      if (i % 3 == 0) val2_in = 32'($urandom_range(0, 40));
      val2_is_imm = 1'($urandom_range(0, 1));
      src1_in = 5'($urandom_range(0, 3)); src2_in = 5'($urandom_range(0, 3));
      dest_in = 5'($urandom); wb_en_in = 1'($urandom); mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom);
      mem_fwd_en = 1'($urandom); mem_fwd_dest = 5'($urandom_range(0, 3)); mem_fwd_val = $urandom;
      wb_fwd_en = 1'($urandom); wb_fwd_dest = 5'($urandom_range(0, 3)); wb_fwd_val = $urandom;
      flush = ($urandom_range(0, 7) == 0);
      if (flush) begin
        e_res = '0; e_st = '0; e_dest = '0; e_ctl = '0;
      end else begin
        e_res  = ref_alu(exe_cmd_in, ref_fwd(src1_in, val1_in, 1'b1), ref_fwd(src2_in, val2_in, !val2_is_imm));
        e_st   = ref_fwd(src2_in, st_value_in, 1'b1);
        e_dest = dest_in;
        e_ctl  = {wb_en_in, mem_r_en_in, mem_w_en_in};
      end
      #1;
      checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL rand_stall[%0d]: got %b expected 0", i, stall); end
      tick();
      checks++;
      if ({alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en} !== {e_res, e_st, e_dest, e_ctl}) begin
        failures++;
        $display("FAIL rand_op[%0d] cmd=%0d: got res=%h st=%h dest=%0d ctl=%b%b%b expected res=%h st=%h dest=%0d ctl=%b",
                 i, exe_cmd_in, alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en, e_res, e_st, e_dest, e_ctl);
      end
    end
    clear_inputs();
  endtask

  // Issues one MUL and follows it to completion, holding inputs while stalled.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d, input logic use_fwd, input string tag);
    logic [31:0] e_res, e_st, sv;
    logic        mw;
    clear_inputs();
    sv = $urandom; mw = 1'($urandom);
    exe_cmd_in = 4'd12; dest_in = d; wb_en_in = 1'b1; mem_w_en_in = mw; st_value_in = sv;
    if (use_fwd) begin
      val1_in = $urandom; val2_in = $urandom; src1_in = 5'd1; src2_in = 5'd2;
      mem_fwd_en = 1'b1; mem_fwd_dest = 5'd1; mem_fwd_val = a;
      wb_fwd_en = 1'b1; wb_fwd_dest = 5'd2; wb_fwd_val = b;
      e_st = b;
    end else begin
      val1_in = a; val2_in = b;
      e_st = sv;
    end
    e_res = ref_alu(4'd12, a, b);
    for (int cyc = 0; cyc <= 32; cyc++) begin
      #1;
      checks++;
      if (stall !== (cyc < 32)) begin failures++; $display("FAIL %s_stall cycle %0d: got %b expected %b", tag, cyc, stall, (cyc < 32)); end
      tick();
      if (use_fwd && cyc + 1 <= 31) begin
        mem_fwd_val = $urandom; wb_fwd_val = $urandom;
      end
      if (cyc + 1 <= 32) begin
        checks++;
        if ({alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en} !== 72'd0) begin
          failures++; $display("FAIL %s_bubble cycle %0d: got res=%h dest=%0d wb=%b expected bubble", tag, cyc + 1, alu_result, dest, wb_en);
        end
      end else begin
        checks++;
        if ({alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en} !== {e_res, e_st, d, 1'b1, 1'b0, mw}) begin
          failures++;
          $display("FAIL %s_result: got res=%h st=%h dest=%0d ctl=%b%b%b expected res=%h st=%h dest=%0d ctl=10%b",
                   tag, alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en, e_res, e_st, d, mw);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_mul();
    run_mul(32'hFFFF_FFFF, 32'd3, 5'd9, 1'b0, "mul_spec");
    checks++;
    if (alu_result !== 32'hFFFF_FFFD) begin failures++; $display("FAIL mul_spec_value: got %h expected %h", alu_result, 32'hFFFF_FFFD); end
    // The instruction right behind the MUL completes normally.
    exe_cmd_in = 4'd0; val1_in = 32'd1; val2_in = 32'd2; dest_in = 5'd8; wb_en_in = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL back_to_back_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if ({alu_result, dest} !== {32'd3, 5'd8}) begin failures++; $display("FAIL back_to_back_add: got %h/%0d expected 3/8", alu_result, dest); end
    run_mul(32'h8000_0000, 32'd2, 5'd1, 1'b0, "mul_wrap");
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0, "mul_neg");
    for (int i = 0; i < 3; i++) run_mul($urandom, $urandom, 5'($urandom), 1'b1, "mul_rand_fwd");
  endtask

  task automatic test_flush();
    // Flush on a single-cycle op.
    clear_inputs();
    exe_cmd_in = 4'd0; val1_in = 32'd4; val2_in = 32'd4; dest_in = 5'd2; wb_en_in = 1'b1; flush = 1'b1;
    tick();
    checks++;
    if ({alu_result, dest, wb_en} !== 38'd0) begin failures++; $display("FAIL flush_alu: got %h/%0d/%b expected bubble", alu_result, dest, wb_en); end
    // Flush on a MUL in IDLE: no stall, no issue.
    exe_cmd_in = 4'd12;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_issue_stall: got %b expected 0", stall); end
    tick();
    // Flush at RUN counter 10 (cycle 11).
    clear_inputs();
    exe_cmd_in = 4'd12; val1_in = 32'd6; val2_in = 32'd7; dest_in = 5'd5; wb_en_in = 1'b1;
    repeat (11) tick();
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_run_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if ({alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en} !== 72'd0) begin
      failures++; $display("FAIL flush_run_bubble: got %h/%0d/%b expected bubble", alu_result, dest, wb_en);
    end
    clear_inputs();
    exe_cmd_in = 4'd0; val1_in = 32'd2; val2_in = 32'd3; dest_in = 5'd4; wb_en_in = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_idle_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if ({alu_result, dest, wb_en} !== {32'd5, 5'd4, 1'b1}) begin failures++; $display("FAIL flush_next_add: got %h/%0d/%b expected 5/4/1", alu_result, dest, wb_en); end
  endtask

  task automatic test_async_reset();
    int nonzero;
    clear_inputs();
    exe_cmd_in = 4'd0; val1_in = 32'd7; val2_in = 32'd8; dest_in = 5'd2; wb_en_in = 1'b1; st_value_in = 32'h33;
    tick();
    exe_cmd_in = 4'd15;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en} !== 72'd0) begin
      failures++; $display("FAIL async_reset_outputs: got %h/%h/%0d/%b expected all zero", alu_result, st_value, dest, wb_en);
    end
    tick();
    #2 rst = 1'b1;
    // Reset during a multiply.
    clear_inputs();
    exe_cmd_in = 4'd12; val1_in = 32'h1234_5678; val2_in = 32'd9; dest_in = 5'd6; wb_en_in = 1'b1;
    repeat (10) tick();
    #2 rst = 1'b0;
    exe_cmd_in = 4'd15;
    #1;
    checks++;
    if ({alu_result, st_value, dest, wb_en, mem_r_en, mem_w_en} !== 72'd0) begin
      failures++; $display("FAIL async_reset_mul_outputs: got %h/%0d/%b expected all zero", alu_result, dest, wb_en);
    end
    tick();
    #2 rst = 1'b1;
    clear_inputs();
    tick();
    exe_cmd_in = 4'd0; val1_in = 32'd1; val2_in = 32'd1; dest_in = 5'd1; wb_en_in = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL async_reset_idle: got stall %b expected 0", stall); end
    tick();
    checks++;
    if ({alu_result, dest, wb_en} !== {32'd2, 5'd1, 1'b1}) begin failures++; $display("FAIL async_reset_add: got %h/%0d/%b expected 2/1/1", alu_result, dest, wb_en); end
    clear_inputs();
    nonzero = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if ({alu_result, dest, wb_en} !== 38'd0) nonzero++;
    end
    checks++;
    if (nonzero !== 0) begin failures++; $display("FAIL async_reset_no_partial: got %0d non-bubble cycles expected 0", nonzero); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_shift_cmp();
    test_random();
    test_mul();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
